// File: rtl/mul_shift_add64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and defaults for the mul_shift_add64
//               shift-add multiplier (state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // State encoding shared by the multiplier FSM
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Default operand width (matches the external 64-bit adder) and
    // iteration counter width (2^CNT_W must exceed WIDTH)
    localparam int WIDTH_DEF = 64;
    localparam int CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_EXEC = EXEC,
        ST_DONE = DONE
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_shift_add64_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add64_if
// Description : Control, operand, result and external-adder signals of the
//               shift-add multiplier. The slave modport is the multiplier;
//               the master modport is the parent (controller + adder).
//               Optional macro MUL_OVF_FLAG_EN adds the ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_shift_add64_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic                 op_start;
    logic                 op_clear;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic                 add_ci;
    logic [WIDTH-1:0]     add_s;
    logic                 add_co;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 op_done;
`ifdef MUL_OVF_FLAG_EN
    logic                 ovf;
`endif

    modport master (
        output op_start,
        output op_clear,
        output multiplicand,
        output multiplier,
        output add_s,
        output add_co,
        input  add_a,
        input  add_b,
        input  add_ci,
        input  result,
        input  busy,
        input  op_done
`ifdef MUL_OVF_FLAG_EN
        ,
        input  ovf
`endif
    );

    modport slave (
        input  op_start,
        input  op_clear,
        input  multiplicand,
        input  multiplier,
        input  add_s,
        input  add_co,
        output add_a,
        output add_b,
        output add_ci,
        output result,
        output busy,
        output op_done
`ifdef MUL_OVF_FLAG_EN
        ,
        output ovf
`endif
    );

endinterface : mul_shift_add64_if
`default_nettype wire

// File: rtl/mul_shift_add64.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add64
// Description : Sequential unsigned radix-2 shift-add multiplier. Uses an
//               external combinational adder as its accumulate stage and
//               produces an exact 2*WIDTH-bit product after WIDTH iterations.
//               Optional macro MUL_OVF_FLAG_EN adds the ovf output, set in
//               DONE when the product does not fit in WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add64
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mul_shift_add64_if.slave bus
);

    // Counter value on the edge that performs the final iteration
    localparam logic [CNT_W-1:0] c_LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic [2*WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]     r_count;
    logic                 w_accept;
    logic                 w_last_iter;

    // A start is only honoured when idle or holding a result, and never
    // together with a clear (clear wins everywhere)
    assign w_accept    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                         bus.op_start && !bus.op_clear;
    assign w_last_iter = (r_count == c_LAST_COUNT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: clear beats start, EXEC runs exactly WIDTH cycles
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.op_clear) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_iter) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.op_clear) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iteration and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else if (bus.op_clear) begin
            r_result <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_mcand  <= bus.multiplicand;
            r_mplr   <= bus.multiplier;
            r_result <= '0;
            r_count  <= '0;
        end else if (r_state == ST_EXEC) begin
            // Adder carry becomes the new top bit, so nothing is lost
            r_result <= {bus.add_co, bus.add_s, r_result[WIDTH-1:1]};
            r_mplr   <= r_mplr >> 1;
            r_count  <= r_count + CNT_W'(1);
        end
    end

    assign bus.add_a   = r_result[2*WIDTH-1:WIDTH];
    assign bus.add_b   = r_mplr[0] ? r_mcand : '0;
    assign bus.add_ci  = 1'b0;
    assign bus.result  = r_result;
    assign bus.busy    = (r_state == ST_EXEC);
    assign bus.op_done = (r_state == ST_DONE);

`ifdef MUL_OVF_FLAG_EN
    assign bus.ovf = (r_state == ST_DONE) && (|r_result[2*WIDTH-1:WIDTH]);
`endif

endmodule : mul_shift_add64
`default_nettype wire
